// File: rtl/ped_pkg.sv
// Shared types and sizes for the pedestrian-request front-end.
package ped_pkg;

   localparam int DB_CNT_W   = 16;
   localparam int WAIT_SEC_W = 8;
   localparam int LOCK_CNT_W = 4;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_PENDING = 2'b01;
   localparam logic [1:0] ST_SERVING = 2'b10;
   localparam logic [1:0] ST_LOCKOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      PENDING = ST_PENDING,
      SERVING = ST_SERVING,
      LOCKOUT = ST_LOCKOUT
   } ped_state_e;

   // Increment that sticks at the all-ones value.
   function automatic logic [WAIT_SEC_W-1:0] sat_inc(input logic [WAIT_SEC_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ped_debounce.sv
// Button front-end: 2-flop synchroniser, consecutive-mismatch debounce counter
// and registered rising-edge detect producing a one-cycle press pulse.
module ped_debounce
   import ped_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic                btn_db_q, btn_db_d;
   logic                btn_db_dly_q, btn_db_dly_d;
   logic                press_q, press_d;
   logic [DB_CNT_W-1:0] cnt_q, cnt_d;

   // Debounced value flips only after DEBOUNCE_CYCLES consecutive mismatches.
   always_comb begin
      sync1_d      = btn_raw;
      sync2_d      = sync1_q;
      btn_db_d     = btn_db_q;
      cnt_d        = '0;
      if (sync2_q != btn_db_q) begin
         if (cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      btn_db_dly_d = btn_db_q;
      press_d      = btn_db_q & ~btn_db_dly_q;
   end

   // Front-end registers, all cleared so a held button re-debounces from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         btn_db_q     <= 1'b0;
         btn_db_dly_q <= 1'b0;
         press_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         btn_db_q     <= btn_db_d;
         btn_db_dly_q <= btn_db_dly_d;
         press_q      <= press_d;
         cnt_q        <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian-request producer: debounced press -> held ped_req until ack,
// crossing phase tracking, post-service lockout, WAIT/WALK LEDs, wait seconds.
// Optional build macro PED_REQUEST_BLINK_EN: WAIT LED toggles on each tick in
// PENDING instead of staying steady.
module ped_request
   import ped_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int LOCKOUT_TICKS   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  ped_btn_raw,
   input  logic                  ped_ack,
   input  logic                  ped_done,
   output logic                  ped_req,
   output logic                  wait_led,
   output logic                  walk_led,
   output logic [WAIT_SEC_W-1:0] wait_sec
);

   localparam logic [LOCK_CNT_W-1:0] LOCK_INIT = LOCK_CNT_W'(LOCKOUT_TICKS);
   localparam logic [LOCK_CNT_W-1:0] LOCK_ONE  = LOCK_CNT_W'(1);

   logic                  press;
   ped_state_e            state_q, state_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [WAIT_SEC_W-1:0] wait_sec_q, wait_sec_d;
   logic                  ped_req_q, ped_req_d;
   logic                  walk_q, walk_d;

   ped_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(ped_btn_raw),
      .press  (press)
   );

   // Next state, lockout countdown, wait-seconds counter and registered outputs.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      wait_sec_d = wait_sec_q;
      case (state_q)
         IDLE: begin
            if (press) begin
               state_d    = PENDING;
               wait_sec_d = '0;
            end
         end
         PENDING: begin
            if (ped_ack) begin
               if (ped_done) begin
                  state_d    = LOCKOUT;
                  lock_cnt_d = LOCK_INIT;
               end else begin
                  state_d = SERVING;
               end
            end else if (tick) begin
               wait_sec_d = sat_inc(wait_sec_q);
            end
         end
         SERVING: begin
            if (ped_done) begin
               state_d    = LOCKOUT;
               lock_cnt_d = LOCK_INIT;
            end
         end
         LOCKOUT: begin
            if (lock_cnt_q == '0) begin
               state_d = IDLE;
            end else if (tick) begin
               lock_cnt_d = lock_cnt_q - 1'b1;
               if (lock_cnt_q == LOCK_ONE) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ped_req_d = (state_d == PENDING);
      walk_d    = (state_d == SERVING);
   end

   // Phase register and output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lock_cnt_q <= '0;
         wait_sec_q <= '0;
         ped_req_q  <= 1'b0;
         walk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         wait_sec_q <= wait_sec_d;
         ped_req_q  <= ped_req_d;
         walk_q     <= walk_d;
      end
   end

`ifdef PED_REQUEST_BLINK_EN
   logic wait_led_q, wait_led_d;

   // WAIT LED starts lit on entry to PENDING and toggles on each tick there.
   always_comb begin
      wait_led_d = 1'b0;
      if (state_d == PENDING) begin
         if (state_q != PENDING) begin
            wait_led_d = 1'b1;
         end else if (tick) begin
            wait_led_d = ~wait_led_q;
         end else begin
            wait_led_d = wait_led_q;
         end
      end
   end

   // Blink toggle flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_led_q <= 1'b0;
      end else begin
         wait_led_q <= wait_led_d;
      end
   end

   assign wait_led = wait_led_q;
`else
   assign wait_led = ped_req_q;
`endif

   assign ped_req  = ped_req_q;
   assign walk_led = walk_q;
   assign wait_sec = wait_sec_q;

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: directed scenarios plus randomized traffic, with a
// behavioural model feeding an expected-output queue checked every cycle.
module tb_ped_request;

   localparam int DB = 4;
   localparam int LT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       ped_btn_raw = 1'b0;
   logic       ped_ack = 1'b0;
   logic       ped_done = 1'b0;
   logic       ped_req;
   logic       wait_led;
   logic       walk_led;
   logic [7:0] wait_sec;

   ped_request #(
      .DEBOUNCE_CYCLES(DB),
      .LOCKOUT_TICKS  (LT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .ped_btn_raw(ped_btn_raw),
      .ped_ack    (ped_ack),
      .ped_done   (ped_done),
      .ped_req    (ped_req),
      .wait_led   (wait_led),
      .walk_led   (walk_led),
      .wait_sec   (wait_sec)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];

   // Behavioural model state
   bit hist[$];     // raw samples, newest first
   bit m_db, m_db_dly, m_press;
   bit m_pend, m_serv, m_lock, m_blink;
   int m_left, m_secs;

   function automatic logic [10:0] m_outputs();
      bit led;
      led = m_pend;
`ifdef PED_REQUEST_BLINK_EN
      led = m_pend & m_blink;
`endif
      return {m_pend, led, m_serv, 8'(m_secs)};
   endfunction

   task automatic m_reset();
      hist = {};
      for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
      m_db = 0; m_db_dly = 0; m_press = 0;
      m_pend = 0; m_serv = 0; m_lock = 0; m_blink = 0;
      m_left = 0; m_secs = 0;
   endtask

   // One clock edge of the model given the inputs sampled at that edge.
   task automatic m_edge(input bit raw, input bit ack, input bit done, input bit tk);
      bit flip;
      bit press_in;
      press_in = m_press;
      // Debounced level changes once the last DB synchronised samples all disagree.
      flip = 1;
      for (int i = 1; i <= DB; i++) if (hist[i] == m_db) flip = 0;
      m_press  = m_db & ~m_db_dly;
      m_db_dly = m_db;
      if (flip) m_db = ~m_db;
      hist.push_front(raw);
      hist.delete(hist.size() - 1);
      if (m_pend) begin
         if (ack) begin
            m_pend = 0;
            if (done) begin m_lock = 1; m_left = LT; end
            else m_serv = 1;
         end else if (tk) begin
            if (m_secs < 255) m_secs++;
            m_blink = ~m_blink;
         end
      end else if (m_serv) begin
         if (done) begin m_serv = 0; m_lock = 1; m_left = LT; end
      end else if (m_lock) begin
         if (tk && m_left > 0) m_left--;
         if (m_left == 0) m_lock = 0;
      end else if (press_in) begin
         m_pend = 1; m_secs = 0; m_blink = 1;
      end
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
      end
   endtask

   task automatic step(input bit raw, input bit ack, input bit done, input bit tk);
      @(negedge clk);
      rst         = 1'b0;
      ped_btn_raw = raw;
      ped_ack     = ack;
      ped_done    = done;
      tick        = tk;
      m_edge(raw, ack, done, tk);
      exp_q.push_back(m_outputs());
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input bit raw);
      @(negedge clk);
      rst         = 1'b1;
      ped_btn_raw = raw;
      ped_ack     = 1'b0;
      ped_done    = 1'b0;
      tick        = 1'b0;
      #1;
      chk("rst_ped_req", int'(ped_req), 0);
      chk("rst_wait_led", int'(wait_led), 0);
      chk("rst_walk_led", int'(walk_led), 0);
      chk("rst_wait_sec", int'(wait_sec), 0);
      m_reset();
      exp_q.push_back(11'd0);
      @(negedge clk);
      exp_q.push_back(11'd0);
   endtask

   // Monitor: compare DUT outputs against the queued expectation after every edge.
   initial begin
      logic [10:0] e;
      logic [10:0] g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {ped_req, wait_led, walk_led, wait_sec};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL scoreboard at %0t: got req=%b wled=%b walk=%b sec=%0d expected req=%b wled=%b walk=%b sec=%0d",
                        $time, g[10], g[9], g[8], g[7:0], e[10], e[9], e[8], e[7:0]);
            end
         end
      end
   end

   initial begin
      bit seen;
      bit raw_state;
      bit prev_req;
      int rises;
      int exp_led;

      m_reset();
      do_reset(1'b0);

      // Clean press: raw high sampled at edge 0, request visible after edge DB+3
      for (int i = 0; i <= DB + 3; i++) begin
         step(1, 0, 0, 0);
         settle();
         if (i == DB + 2) chk("latency_early", int'(ped_req), 0);
         if (i == DB + 3) begin
            chk("latency_req", int'(ped_req), 1);
            chk("latency_wait_led", int'(wait_led), 1);
         end
      end

      // Five seconds waited, then ack coinciding with a tick
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
      step(1, 1, 0, 1);
      settle();
      chk("ack_req_fall", int'(ped_req), 0);
      chk("ack_walk_rise", int'(walk_led), 1);
      chk("ack_wait_sec", int'(wait_sec), 5);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      settle();
      chk("done_walk_fall", int'(walk_led), 0);

      // Button pressed during lockout is discarded
      for (int i = 0; i < 12; i++) step(1, 0, 0, (i % 4) == 3);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      settle();
      chk("lockout_discard", int'(ped_req), 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
      for (int i = 0; i <= DB + 3; i++) step(1, 0, 0, 0);
      settle();
      chk("press_after_lockout", int'(ped_req), 1);

      // Ack and done together go straight to lockout
      step(1, 1, 1, 0);
      settle();
      chk("ackdone_req", int'(ped_req), 0);
      chk("ackdone_walk", int'(walk_led), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

      // WAIT LED pattern over four ticks in PENDING
      for (int i = 0; i <= DB + 3; i++) step(1, 0, 0, 0);
      settle();
      chk("blink_entry", int'(wait_led), 1);
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 0, 1);
         settle();
`ifdef PED_REQUEST_BLINK_EN
         exp_led = (k % 2 == 0) ? 0 : 1;
`else
         exp_led = 1;
`endif
         chk("blink_seq", int'(wait_led), exp_led);
      end

      // Saturation of wait_sec, then tick+ack together
      for (int i = 0; i < 300; i++) step(1, 0, 0, 1);
      settle();
      chk("sat_wait_sec", int'(wait_sec), 255);
      step(1, 1, 0, 1);
      settle();
      chk("sat_ack_walk", int'(walk_led), 1);
      chk("sat_ack_sec", int'(wait_sec), 255);
      step(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

      // Bounce rejection: raw toggles every 3 cycles
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         step((i < 40) && ((i / 3) % 2 == 0), 0, 0, 0);
         settle();
         if (ped_req) seen = 1;
      end
      chk("bounce_no_req", int'(seen), 0);

      // Reset mid-request with button held through release
      for (int i = 0; i <= DB + 3; i++) step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      settle();
      chk("pre_reset_sec", int'(wait_sec), 2);
      do_reset(1'b1);
      rises = 0;
      prev_req = 0;
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0, 0);
         settle();
         if (ped_req && !prev_req) rises++;
         prev_req = ped_req;
      end
      chk("reset_one_request", rises, 1);
      step(1, 1, 0, 0);
      step(0, 0, 1, 0);

      // Randomized traffic
      raw_state = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 799) == 0) begin
            do_reset(raw_state);
         end else begin
            if ($urandom_range(0, 29) == 0) raw_state = ~raw_state;
            step(raw_state, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0);
         end
      end

      step(0, 0, 0, 0);
      settle();
      chk("queue_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ped_request.md
# ped_request

Pedestrian-request front-end: the producer side of the pedestrian request interface consumed by the traffic-light controller. It synchronises and debounces the raw push-button and turns a press into a level request held until the controller accepts it. It then tracks the crossing phase and enforces a post-service lockout. It also drives the WAIT/WALK indicator LEDs and a seconds-waited counter, and sits between the board button pin and the controller's `ped_btn` input.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive `clk` cycles the synchronised button must differ from the debounced value before the debounced value changes; legal range 1..65535.
- `LOCKOUT_TICKS`, default 3: `tick` pulses after service during which presses are ignored; legal range 0..15.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle 1 Hz enable, synchronous to `clk`.
- `ped_btn_raw`  in  1  raw button, asynchronous, active-high.
- `ped_ack`  in  1  controller accepted the request; one-cycle pulse.
- `ped_done`  in  1  crossing phase finished; one-cycle pulse.
- `ped_req`  out  1  pending request, held high until `ped_ack`.
- `wait_led`  out  1  WAIT indicator.
- `walk_led`  out  1  WALK indicator.
- `wait_sec`  out  8  whole seconds the current or last request waited, saturating.

## Operation
- Front-end:
  - 2-flop synchroniser, then debounce counter (16-bit).
  - Counter clears whenever the synchronised value equals `btn_db`.
  - When it reaches `DEBOUNCE_CYCLES` consecutive mismatches, `btn_db` takes the synchronised value and the counter clears.
  - A press event is a registered rising edge of `btn_db`.
- States: IDLE, PENDING, SERVING, LOCKOUT.
  - IDLE: a press event moves to PENDING and clears `wait_sec` to 0.
  - PENDING: `ped_ack` moves to SERVING. If `ped_ack` and `ped_done` arrive in the same cycle, go directly to LOCKOUT.
  - SERVING: `ped_done` moves to LOCKOUT and loads the lockout counter with `LOCKOUT_TICKS`.
  - LOCKOUT: each `tick` decrements the counter; at 0 go to IDLE. With `LOCKOUT_TICKS`=0, LOCKOUT lasts exactly one cycle.
  - `ped_ack` outside PENDING and `ped_done` outside SERVING/PENDING are ignored.
  - Press events in PENDING, SERVING and LOCKOUT are discarded; they are not queued.
- Outputs:
  - `ped_req` = 1 exactly in PENDING, registered.
  - `walk_led` = 1 exactly in SERVING.
  - `wait_led` = 0 outside PENDING.
  - `wait_sec` increments on `tick` in PENDING only, saturates at 255, and holds its value in all other states.
  - If `tick` and `ped_ack` coincide in PENDING, `wait_sec` does not increment.
- Reset (async, immediate):
  - State IDLE; sync flops, `btn_db`, debounce and lockout counters = 0.
  - `ped_req`=0, `wait_led`=0, `walk_led`=0, `wait_sec`=0.
  - Reset mid-request drops `ped_req` immediately with no ack required. A button held through reset release must re-debounce from 0 and produces one press event.

## Timing
- Latency: a clean raw step sampled high at edge 0 raises `ped_req` after edge `DEBOUNCE_CYCLES`+3.
- Bounces shorter than `DEBOUNCE_CYCLES` cycles never produce a press event.
- `ped_req` falls on the edge after `ped_ack` is sampled; `walk_led` rises on the same edge.
- `walk_led` falls on the edge after `ped_done` is sampled.
- Release from LOCKOUT occurs on the edge that samples the `LOCKOUT_TICKS`-th `tick`. A press event in that same cycle is discarded.
- No combinational path from any input to any output.

## Configuration
- `PED_REQUEST_BLINK_EN` defined:
  - `wait_led` is 1 on entry to PENDING and toggles on every `tick` while in PENDING.
  - This gives a 0.5 Hz blink.
- `PED_REQUEST_BLINK_EN` undefined:
  - `wait_led` is steady 1 throughout PENDING.
  - The toggle flop is not built.

## Structure
- Package `ped_pkg` holds:
  - State encoding localparams: IDLE=2'b00, PENDING=2'b01, SERVING=2'b10, LOCKOUT=2'b11.
  - Debounce counter width (16), `wait_sec` width (8) and lockout counter width (4).
- Sub-module `ped_debounce`: synchroniser, debounce counter and rising-edge detect. Ports `clk`, `rst`, raw input, registered press-event pulse. `ped_request` instantiates it once.

## Test plan
- Clean press (`DEBOUNCE_CYCLES`=4): raw high at edge 0 → `ped_req` high after edge 7; `wait_led`=1.
- Bounce rejection (`DEBOUNCE_CYCLES`=4): raw toggles every 3 cycles for 40 cycles, then low → `ped_req` never asserts.
- Full handshake:
  - Press, 5 `tick`s, then `ped_ack` → `ped_req` falls next edge, `walk_led` rises, `wait_sec`=5.
  - `ped_done` → `walk_led` falls.
  - With `LOCKOUT_TICKS`=3: presses during 3 `tick`s are ignored; a press after the 3rd `tick` is accepted.
- Saturation: hold PENDING for 300 `tick`s → `wait_sec`=255. Simultaneous `tick`+`ped_ack` → no increment, state SERVING.
- Reset mid-request: `rst` pulse in PENDING → `ped_req`, `wait_led`, `wait_sec` = 0 before the next edge. Button held through release → exactly one new request.
- Blink, with `PED_REQUEST_BLINK_EN`: `wait_led` sequence over 4 `tick`s in PENDING is 1,0,1,0,1. Without the macro: constant 1.
